// File: rtl/lifo_unloader_pkg.sv
// lifo_unloader_pkg: shared state encoding and constants for the LIFO drain stage.
package lifo_unloader_pkg;
   typedef enum logic [2:0] {IDLE, POP, CAPT, HOLD, CHK, FIN} state_t;
   localparam int DATA_W_DEF = 8;
   localparam int CHK_INIT = 0;
endpackage

// File: rtl/lifo_unloader_chksum.sv
// lifo_unloader_chksum: byte-sum accumulator, cleared on start, carries discarded.
module lifo_unloader_chksum
   import lifo_unloader_pkg::*;
#(
   parameter int DATA_W = DATA_W_DEF
) (
   input  logic              clk,
   input  logic              rst,
   input  logic              clr,
   input  logic              en,
   input  logic [DATA_W-1:0] d,
   output logic [DATA_W-1:0] sum
);
   always_ff @(posedge clk)
      sum <= (rst || clr) ? DATA_W'(CHK_INIT) : en ? sum + d : sum;
endmodule

// File: rtl/lifo_unloader.sv
// lifo_unloader: pops up to MAX_LEN bytes off the LIFO stack onto a valid/ready stream.
// Define LIFO_UNLOADER_CHKSUM_EN to append a byte-sum beat carrying m_last.
module lifo_unloader
   import lifo_unloader_pkg::*;
#(
   parameter int DATA_W  = DATA_W_DEF,
   parameter int MAX_LEN = 8,
   parameter int CNT_W   = $clog2(MAX_LEN + 1)
) (
   input  logic              clk,
   input  logic              rst,
   input  logic              start,
   output logic              busy,
   output logic              done,
   output logic [CNT_W-1:0]  cnt,
   output logic              stk_rd,
   input  logic              stk_empty,
   input  logic [DATA_W-1:0] stk_data,
   output logic [DATA_W-1:0] m_data,
   output logic              m_valid,
   input  logic              m_ready,
   output logic              m_last
);
   state_t state;
   logic last_q;
   logic at_end;
   logic [DATA_W-1:0] sum;
`ifdef LIFO_UNLOADER_CHKSUM_EN
   localparam bit CHK_EN = 1'b1;
   lifo_unloader_chksum #(.DATA_W(DATA_W)) u_chksum (
      .clk(clk),
      .rst(rst),
      .clr(start && state == IDLE),
      .en(state == CAPT),
      .d(stk_data),
      .sum(sum)
   );
`else
   localparam bit CHK_EN = 1'b0;
   assign sum = '0;
`endif
   // stk_empty already reflects the pop issued in POP when sampled in CAPT
   assign at_end = stk_empty || (cnt + CNT_W'(1) == CNT_W'(MAX_LEN));
   always_ff @(posedge clk)
      if (rst) begin
         state   <= IDLE;
         busy    <= 1'b0;
         done    <= 1'b0;
         cnt     <= '0;
         stk_rd  <= 1'b0;
         m_valid <= 1'b0;
         m_last  <= 1'b0;
         m_data  <= '0;
         last_q  <= 1'b0;
      end else begin
         done   <= 1'b0;
         stk_rd <= 1'b0;
         case (state)
            IDLE: if (start) begin
               busy <= 1'b1;
               cnt  <= '0;
               if (!stk_empty) begin
                  state  <= POP;
                  stk_rd <= 1'b1;
               end else if (CHK_EN) begin
                  state   <= CHK;
                  m_data  <= DATA_W'(CHK_INIT);
                  m_valid <= 1'b1;
                  m_last  <= 1'b1;
               end else begin
                  state <= FIN;
                  done  <= 1'b1;
               end
            end
            POP: state <= CAPT;
            CAPT: begin
               m_data  <= stk_data;
               m_valid <= 1'b1;
               m_last  <= !CHK_EN && at_end;
               last_q  <= at_end;
               cnt     <= cnt + CNT_W'(1);
               state   <= HOLD;
            end
            HOLD: if (m_ready) begin
               m_valid <= 1'b0;
               m_last  <= 1'b0;
               if (!last_q) begin
                  state  <= POP;
                  stk_rd <= 1'b1;
               end else if (CHK_EN) begin
                  state   <= CHK;
                  m_data  <= sum;
                  m_valid <= 1'b1;
                  m_last  <= 1'b1;
               end else begin
                  state <= FIN;
                  done  <= 1'b1;
               end
            end
            CHK: if (m_ready) begin
               m_valid <= 1'b0;
               m_last  <= 1'b0;
               state   <= FIN;
               done    <= 1'b1;
            end
            FIN: begin
               busy  <= 1'b0;
               state <= IDLE;
            end
            default: state <= IDLE;
         endcase
      end
endmodule

// File: tb/tb_lifo_unloader.sv
// tb_lifo_unloader: directed checks of the LIFO drain stage against a behavioural 8-deep stack.
module tb_lifo_unloader;
   logic clk = 1'b0;
   logic rst = 1'b1;
   logic start = 1'b0;
   logic busy, done, stk_rd, m_valid, m_last;
   logic m_ready = 1'b1;
   logic [2:0] cnt;
   logic [7:0] stk_data, m_data;
   logic stk_empty;
   logic stk_init = 1'b1;
   logic push = 1'b0;
   logic [7:0] push_d = '0;
   logic [7:0] mem [0:7];
   logic [3:0] sp;
   int n_chk = 0;
   int n_fail = 0;
   int n_rd = 0;
   logic [7:0] got_d [$];
   logic got_l [$];
   logic [7:0] exp_q [$];
   logic p_rd = 1'b0, p_v = 1'b0, p_r = 1'b0, p_l = 1'b0;
   logic [7:0] p_d = '0;
   int base, rd_base;
   logic [2:0] dcnt;
`ifdef LIFO_UNLOADER_CHKSUM_EN
   localparam int CK = 1;
`else
   localparam int CK = 0;
`endif

   always #5 clk = ~clk;

   lifo_unloader #(.DATA_W(8), .MAX_LEN(4)) dut (
      .clk(clk), .rst(rst), .start(start), .busy(busy), .done(done), .cnt(cnt),
      .stk_rd(stk_rd), .stk_empty(stk_empty), .stk_data(stk_data),
      .m_data(m_data), .m_valid(m_valid), .m_ready(m_ready), .m_last(m_last)
   );

   assign stk_empty = (sp == 0);

   always @(posedge clk)
      if (stk_init) begin
         sp <= '0;
         stk_data <= '0;
      end else if (push) begin
         mem[sp[2:0]] <= push_d;
         sp <= sp + 1;
      end else if (stk_rd && sp != 0) begin
         stk_data <= mem[3'(sp - 1)];
         sp <= sp - 1;
      end

   task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_chk++;
      if (got !== exp) begin
         n_fail++;
         $display("FAIL %s: got %0h expected %0h", tag, got, exp);
      end
   endtask

   always @(negedge clk) begin
      if (m_valid && m_ready) begin
         got_d.push_back(m_data);
         got_l.push_back(m_last);
      end
      if (stk_rd) begin
         n_rd++;
         check("rd_pend", m_valid, 0);
         check("rd_consec", p_rd, 0);
      end
      if (m_valid && p_v && !p_r) begin
         check("stall_data", m_data, p_d);
         check("stall_last", m_last, p_l);
      end
      p_rd = stk_rd; p_v = m_valid; p_r = m_ready; p_d = m_data; p_l = m_last;
   end

   task automatic cyc();
      @(posedge clk);
      #1;
   endtask

   task automatic push_byte(input logic [7:0] v);
      push = 1'b1;
      push_d = v;
      cyc();
      push = 1'b0;
   endtask

   task automatic do_start();
      base = got_d.size();
      rd_base = n_rd;
      start = 1'b1;
      cyc();
      start = 1'b0;
   endtask

   task automatic wait_valid(input string tag);
      logic ok = 1'b0;
      for (int i = 0; i < 50 && !ok; i++) begin
         if (m_valid) ok = 1'b1;
         else cyc();
      end
      check({tag, "_valid_seen"}, ok, 1);
   endtask

   task automatic wait_done(input string tag);
      logic ok = 1'b0;
      for (int i = 0; i < 300 && !ok; i++) begin
         @(negedge clk);
         if (done) begin
            ok = 1'b1;
            dcnt = cnt;
         end
      end
      check({tag, "_done_seen"}, ok, 1);
      cyc();
   endtask

   task automatic check_xfer(input string tag, input int exp_cnt);
      logic [7:0] s;
      int n;
      s = '0;
      foreach (exp_q[i]) s = s + exp_q[i];
      if (CK == 1) exp_q.push_back(s);
      n = got_d.size() - base;
      check({tag, "_nbeats"}, n, exp_q.size());
      for (int i = 0; i < exp_q.size() && i < n; i++) begin
         check({tag, "_data"}, got_d[base + i], exp_q[i]);
         check({tag, "_last"}, got_l[base + i], (i == exp_q.size() - 1));
      end
      check({tag, "_cnt"}, dcnt, exp_cnt);
      check({tag, "_pops"}, n_rd - rd_base, exp_cnt);
      check({tag, "_busy_after"}, busy, 0);
   endtask

   initial begin
      #200000;
      $display("FAIL watchdog: got timeout expected finish");
      $fatal(1, "watchdog");
   end

   initial begin
      cyc(); cyc();
      check("rst_busy", busy, 0);
      check("rst_done", done, 0);
      check("rst_cnt", cnt, 0);
      check("rst_stk_rd", stk_rd, 0);
      check("rst_valid", m_valid, 0);
      check("rst_last", m_last, 0);
      check("rst_data", m_data, 0);
      rst = 1'b0;
      stk_init = 1'b0;
      cyc();
      // basic transfer with latency checks
      push_byte(8'h11); push_byte(8'h22); push_byte(8'h33);
      m_ready = 1'b1;
      do_start();
      check("t1_rd_lat", stk_rd, 1);
      check("t1_busy", busy, 1);
      cyc(); cyc();
      check("t1_valid_lat", m_valid, 1);
      wait_done("t1");
      exp_q = '{8'h33, 8'h22, 8'h11};
      check_xfer("t1", 3);
      // backpressure: five stalled cycles per beat
      push_byte(8'h11); push_byte(8'h22); push_byte(8'h33);
      m_ready = 1'b0;
      do_start();
      for (int b = 0; b < 3 + CK; b++) begin
         wait_valid("t2");
         repeat (5) cyc();
         m_ready = 1'b1;
         cyc();
         m_ready = 1'b0;
      end
      wait_done("t2");
      exp_q = '{8'h33, 8'h22, 8'h11};
      check_xfer("t2", 3);
      // empty stack
      m_ready = 1'b1;
      do_start();
      check("t3_rd", stk_rd, 0);
      if (CK == 1) begin
         check("t3_done_early", done, 0);
         cyc();
      end
      check("t3_done", done, 1);
      check("t3_cnt", cnt, 0);
      dcnt = cnt;
      cyc(); cyc();
      exp_q = {};
      check_xfer("t3", 0);
      // MAX_LEN limit
      for (int v = 1; v <= 8; v++) push_byte(8'(v));
      do_start();
      wait_done("t4");
      exp_q = '{8'h08, 8'h07, 8'h06, 8'h05};
      check_xfer("t4", 4);
      check("t4_left", sp, 4);
      // reset while second beat is held
      m_ready = 1'b0;
      do_start();
      wait_valid("t5a");
      m_ready = 1'b1;
      cyc();
      m_ready = 1'b0;
      wait_valid("t5b");
      check("t5_hold_data", m_data, 8'h03);
      rst = 1'b1;
      cyc();
      check("t5_rst_valid", m_valid, 0);
      check("t5_rst_busy", busy, 0);
      check("t5_rst_last", m_last, 0);
      rst = 1'b0;
      m_ready = 1'b1;
      cyc();
      do_start();
      wait_done("t5");
      exp_q = '{8'h02, 8'h01};
      check_xfer("t5", 2);
      // checksum wrap pattern
      push_byte(8'h80); push_byte(8'h90);
      do_start();
      wait_done("t6");
      exp_q = '{8'h90, 8'h80};
      check_xfer("t6", 2);
      $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
      $finish;
   end
endmodule
